// File: rtl/weight_fetch_seq.sv
// Weight fetch sequencer: issues a burst of single-word RAM reads and streams the
// returned words to the neuron MAC through a small credit-protected FIFO.
module weight_fetch_seq #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  output logic              ram_req,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_ack,
  input  logic              ram_rvalid,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              w_valid,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last,
  input  logic              w_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W+1:0] CREDIT_MAX = (PTR_W+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} seqStateT;

  seqStateT           state, stateNext;
  logic [CNT_W-1:0]   numWordsQ, issued, received, consumed;
  logic [ADDR_W-1:0]  addrQ;
  logic [PTR_W:0]     outstanding, fifoCnt;
  logic [PTR_W-1:0]   wrPtr, rdPtr;
  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W+1:0]   creditUsed;
  logic               zeroDone, drainDone, startAccept, reqAck, fifoWr, fifoRd;

  // Credit covers both in-flight requests and buffered words, so a granted
  // request always has a FIFO slot waiting for its return.
  always_comb begin
    stateNext   = state;
    startAccept = 1'b0;
    drainDone   = 1'b0;
    creditUsed  = {1'b0, outstanding} + {1'b0, fifoCnt};
    ram_req     = (state == FETCH) && (creditUsed < CREDIT_MAX);
    reqAck      = ram_req && ram_ack;
    case (state)
      IDLE: begin
        if (start && (num_words != '0)) begin
          startAccept = 1'b1;
          stateNext   = FETCH;
        end
      end
      FETCH: begin
        if (reqAck && (issued == numWordsQ - 1'b1)) stateNext = DRAIN;
      end
      DRAIN: begin
        if ((received == numWordsQ) && (fifoCnt == '0)) begin
          drainDone = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign fifoWr   = ram_rvalid && (state != IDLE);
  assign w_valid  = (fifoCnt != '0);
  assign fifoRd   = w_valid && w_ready;
  assign w_data   = mem[rdPtr];
  assign w_last   = w_valid && (consumed == numWordsQ - 1'b1);
  assign ram_addr = addrQ;
  assign busy     = (state != IDLE) && !drainDone;
  assign done     = drainDone || zeroDone;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      zeroDone    <= 1'b0;
      numWordsQ   <= '0;
      issued      <= '0;
      received    <= '0;
      consumed    <= '0;
      addrQ       <= '0;
      outstanding <= '0;
      fifoCnt     <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state    <= stateNext;
      zeroDone <= (state == IDLE) && start && (num_words == '0);
      if (startAccept) begin
        numWordsQ <= num_words;
        addrQ     <= base_addr;
        issued    <= '0;
        received  <= '0;
        consumed  <= '0;
      end else begin
        if (reqAck) begin
          issued <= issued + 1'b1;
          addrQ  <= addrQ + 1'b1;
        end
        if (fifoWr) received <= received + 1'b1;
        if (fifoRd) consumed <= consumed + 1'b1;
      end
      case ({reqAck, fifoWr})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (fifoWr) begin
        mem[wrPtr] <= ram_rdata;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (fifoRd) rdPtr <= rdPtr + 1'b1;
      case ({fifoWr, fifoRd})
        2'b10:   fifoCnt <= fifoCnt + 1'b1;
        2'b01:   fifoCnt <= fifoCnt - 1'b1;
        default: fifoCnt <= fifoCnt;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fetch_seq.sv
// Randomized bench for weight_fetch_seq: transaction-level model of a burst
// (addresses, credit, returns, consumption) compared against the DUT each cycle.
module tb_weight_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [7:0]  num_words = '0;
  logic        busy, done, ram_req;
  logic [15:0] ram_addr;
  logic        ram_ack = 1'b0;
  logic        ram_rvalid = 1'b0;
  logic [15:0] ram_rdata = '0;
  logic        w_valid;
  logic [15:0] w_data;
  logic        w_last;
  logic        w_ready = 1'b0;

  always #5 clk = ~clk;

  weight_fetch_seq #(
    .ADDR_W(16), .DATA_W(16), .CNT_W(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .ram_req(ram_req),
    .ram_addr(ram_addr), .ram_ack(ram_ack), .ram_rvalid(ram_rvalid),
    .ram_rdata(ram_rdata), .w_valid(w_valid), .w_data(w_data),
    .w_last(w_last), .w_ready(w_ready)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
  } retT;

  int checks = 0;
  int failures = 0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] ramWord(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5AC3;
  endfunction

  // Burst model state
  bit          mActive = 0, doneNext = 0, sawDone = 0, consumedAny = 0;
  bit          prevStall = 0, strayRv = 0;
  logic [15:0] mBase = '0, prevData = '0;
  int          mN = 0, mIssued = 0, mOut = 0, mFifo = 0, mConsumed = 0;
  int          cyc = 0, acksPre = 0;
  int          ackMax = 0, readyPct = 100, rvLat = 2, stallLeft = 0;
  int          ackCnt = 0, ackTarget = 0;
  retT         rvQ[$];

  task automatic cycle();
    bit          doneNow, wasActive, reqExp;
    retT         r;
    doneNow   = doneNext;
    doneNext  = 0;
    wasActive = mActive;
    checkEq("done", done, doneNow);
    checkEq("busy", busy, mActive && !doneNow);
    reqExp = mActive && (mIssued < mN) && (mOut + mFifo < 4);
    checkEq("ram_req", ram_req, reqExp);
    if (ram_req) checkEq("ram_addr", ram_addr, 16'(mBase + 16'(mIssued)));
    checkEq("w_valid", w_valid, mFifo > 0);
    if (w_valid && mFifo > 0) begin
      checkEq("w_data", w_data, ramWord(16'(mBase + 16'(mConsumed))));
      checkEq("w_last", w_last, mConsumed == mN - 1);
    end else begin
      checkEq("w_last_idle", w_last, 0);
    end
    if (prevStall) checkEq("w_hold", w_data, prevData);
    checkEq("credit", (mOut + mFifo) <= 4, 1);

    w_ready = (stallLeft > 0) ? 1'b0 : ($urandom_range(99) < readyPct);
    if (stallLeft > 0) stallLeft--;
    ram_ack = 1'b0;
    if (ram_req) begin
      if (ackCnt >= ackTarget) begin
        ram_ack   = 1'b1;
        ackCnt    = 0;
        ackTarget = $urandom_range(ackMax, 0);
      end else begin
        ackCnt++;
      end
    end
    ram_rvalid = 1'b0;
    ram_rdata  = 16'($urandom);
    if (strayRv) begin
      ram_rvalid = 1'b1;
      ram_rdata  = 16'hDEAD;
    end else if (rvQ.size() > 0 && rvQ[0].due <= cyc) begin
      r          = rvQ.pop_front();
      ram_rvalid = 1'b1;
      ram_rdata  = r.data;
    end

    if (ram_req && ram_ack) begin
      rvQ.push_back('{due: cyc + rvLat, data: ramWord(ram_addr)});
      mIssued++;
      mOut++;
      if (!consumedAny) acksPre++;
    end
    if (ram_rvalid && wasActive) begin
      mOut--;
      mFifo++;
    end
    if (w_valid && w_ready) begin
      mFifo--;
      mConsumed++;
      consumedAny = 1;
      if (mConsumed == mN) doneNext = 1;
    end
    prevStall = w_valid && !w_ready;
    prevData  = w_data;
    if (doneNow) begin
      mActive = 0;
      sawDone = 1;
    end
    if (start && !wasActive) begin
      if (num_words != 0) begin
        mActive     = 1;
        mBase       = base_addr;
        mN          = num_words;
        mIssued     = 0;
        mConsumed   = 0;
        consumedAny = 0;
        acksPre     = 0;
      end else begin
        doneNext = 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic launch(input logic [15:0] b, input int n, input int am, input int pct, input int stall);
    ackMax    = am;
    readyPct  = pct;
    stallLeft = stall;
    ackCnt    = 0;
    ackTarget = $urandom_range(am, 0);
    sawDone   = 0;
    start     = 1'b1;
    base_addr = b;
    num_words = 8'(n);
    cycle();
    start     = 1'b0;
    base_addr = 16'($urandom);
    num_words = 8'($urandom);
  endtask

  task automatic runBurst(input logic [15:0] b, input int n, input int am, input int pct,
                          input int stall, input bit midStart);
    launch(b, n, am, pct, stall);
    for (int k = 0; k < 3000 && !sawDone; k++) begin
      if (midStart && k == 3) begin
        start     = 1'b1;
        base_addr = 16'hBEEF;
        num_words = 8'd7;
      end
      cycle();
      start = 1'b0;
    end
    checkEq("burst_done", sawDone, 1);
    cycle();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkEq({tag, "_busy"}, busy, 0);
    checkEq({tag, "_done"}, done, 0);
    checkEq({tag, "_ram_req"}, ram_req, 0);
    checkEq({tag, "_ram_addr"}, ram_addr, 0);
    checkEq({tag, "_w_valid"}, w_valid, 0);
    checkEq({tag, "_w_data"}, w_data, 0);
    checkEq({tag, "_w_last"}, w_last, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("rst");
    rst_n = 1'b1;
    cycle();

    runBurst(16'h0100, 3, 0, 100, 0, 0);
    runBurst(16'h2000, 10, 0, 100, 20, 0);
    checkEq("acks_before_consume", acksPre, 4);
    runBurst(16'h3A00, 12, 3, 70, 0, 0);
    runBurst(16'h1234, 0, 0, 100, 0, 0);
    runBurst(16'hFFFF, 3, 0, 100, 0, 0);
    runBurst(16'h0200, 6, 1, 80, 0, 1);
    for (int i = 0; i < 6; i++)
      runBurst(16'($urandom), $urandom_range(20, 1), $urandom_range(3, 0),
               $urandom_range(100, 30), $urandom_range(8, 0), 0);

    // Abort a burst after two words have been delivered.
    launch(16'h4000, 8, 1, 100, 0);
    for (int k = 0; k < 500 && mConsumed < 2; k++) cycle();
    checkEq("two_delivered", mConsumed, 2);
    #3;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    mActive = 0; doneNext = 0; mOut = 0; mFifo = 0; prevStall = 0;
    rvQ.delete();
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst_n   = 1'b1;
    strayRv = 1;
    cycle();
    strayRv = 0;
    cycle();
    cycle();
    runBurst(16'h5000, 2, 1, 100, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
